// File: rtl/transport_pkg.sv
// Shared transport constants, receive FSM state encoding and header classification.
// Used by both the transport send and receive stages.
package transport_pkg;

    localparam logic [7:0] HDR_CTRL    = 8'h40;
    localparam logic [7:0] HDR_AUDIO   = 8'h81;
    localparam logic [7:0] AUD_TRAILER = 8'hFF;
    localparam logic [7:0] CTRL_PAD    = 8'h00;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_HDR     = 4'd1,
        ST_CTRL_HI = 4'd2,
        ST_CTRL_LO = 4'd3,
        ST_PAD     = 4'd4,
        ST_AUD_HI  = 4'd5,
        ST_AUD_LO  = 4'd6,
        ST_TRAIL   = 4'd7,
        ST_DROP    = 4'd8
    } rx_state_t;

    // Maps a header byte to the state that handles the packet's second byte.
    function automatic rx_state_t hdr_next_state(input logic [7:0] hdr);
        rx_state_t st;
        case (hdr)
            HDR_CTRL:  st = ST_CTRL_HI;
            HDR_AUDIO: st = ST_AUD_HI;
            default:   st = ST_DROP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/transport_receive_if.sv
// Byte-stream input and decoded word output of the transport receive stage.
// master: byte source / word consumer; slave: transport_receive.
interface transport_receive_if;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [1:0]  cmd_out;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        pkt_error;

    modport master (
        output byte_in, byte_valid,
        input  cmd_out, data_out, data_valid, busy, pkt_error
    );

    modport slave (
        input  byte_in, byte_valid,
        output cmd_out, data_out, data_valid, busy, pkt_error
    );

endinterface

// File: rtl/transport_receive.sv
// Transport receive stage: rebuilds PACKET_SIZE-byte packets and emits 16-bit control/audio words.
// TRANSPORT_RCV_CHECK_EN: also flag unknown headers, nonzero control padding and bad audio trailers.
module transport_receive
    import transport_pkg::*;
#(
    parameter int PACKET_SIZE = 16
) (
    input  logic               clk,
    input  logic               reset,
    transport_receive_if.slave bus
);

`ifdef TRANSPORT_RCV_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [7:0] LAST_CNT    = 8'(PACKET_SIZE - 1);
    // cnt of the low byte of the final whole sample; an odd spare byte after it is skipped in TRAIL
    localparam logic [7:0] LAST_LO_CNT = 8'(((PACKET_SIZE - 2) / 2) * 2);

    rx_state_t   state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [7:0]  hi_r, hi_s;
    logic        bad_r, bad_s;
    logic [1:0]  cmd_r, cmd_s;
    logic [15:0] data_r, data_s;
    logic        data_valid_r, data_valid_s;
    logic        busy_r, busy_s;
    logic        pkt_error_r, pkt_error_s;
    logic        last_s;
    logic        bad_now_s;

    // State, counter, holding register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            hi_r         <= 8'd0;
            bad_r        <= 1'b0;
            cmd_r        <= CMD_IDLE;
            data_r       <= 16'd0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            pkt_error_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            hi_r         <= hi_s;
            bad_r        <= bad_s;
            cmd_r        <= cmd_s;
            data_r       <= data_s;
            data_valid_r <= data_valid_s;
            busy_r       <= busy_s;
            pkt_error_r  <= pkt_error_s;
        end
    end

    // Next-state, byte counter, word extraction and error detection.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        hi_s         = hi_r;
        bad_s        = bad_r;
        cmd_s        = CMD_IDLE;
        data_s       = data_r;
        data_valid_s = 1'b0;
        busy_s       = busy_r;
        pkt_error_s  = 1'b0;
        bad_now_s    = 1'b0;
        last_s       = (cnt_r == LAST_CNT);

        if (!bus.byte_valid) begin
            // cnt 0 means we sit on a packet boundary; anything else is a truncation
            state_s     = ST_IDLE;
            cnt_s       = 8'd0;
            bad_s       = 1'b0;
            busy_s      = 1'b0;
            pkt_error_s = (cnt_r != 8'd0);
        end else begin
            busy_s = 1'b1;
            cnt_s  = last_s ? 8'd0 : cnt_r + 8'd1;
            case (state_r)
                ST_IDLE, ST_HDR: begin
                    state_s   = hdr_next_state(bus.byte_in);
                    bad_now_s = (state_s == ST_DROP);
                end
                ST_CTRL_HI: begin
                    hi_s    = bus.byte_in;
                    state_s = ST_CTRL_LO;
                end
                ST_CTRL_LO: begin
                    data_s       = {hi_r, bus.byte_in};
                    cmd_s        = CMD_CTRL;
                    data_valid_s = 1'b1;
                    state_s      = ST_PAD;
                end
                ST_PAD: begin
                    bad_now_s = (bus.byte_in != CTRL_PAD);
                end
                ST_AUD_HI: begin
                    hi_s    = bus.byte_in;
                    state_s = ST_AUD_LO;
                end
                ST_AUD_LO: begin
                    data_s       = {hi_r, bus.byte_in};
                    cmd_s        = CMD_AUDIO;
                    data_valid_s = 1'b1;
                    state_s      = (cnt_r == LAST_LO_CNT) ? ST_TRAIL : ST_AUD_HI;
                end
                ST_TRAIL: begin
                    bad_now_s = last_s && (bus.byte_in != AUD_TRAILER);
                end
                ST_DROP: begin
                    bad_now_s = 1'b0;
                end
                default: begin
                    state_s = ST_DROP;
                end
            endcase

            if (last_s) begin
                state_s     = ST_HDR;
                bad_s       = 1'b0;
                pkt_error_s = CHECK_EN && (bad_r || bad_now_s);
            end else begin
                bad_s = bad_r || bad_now_s;
            end
        end
    end

    assign bus.cmd_out    = cmd_r;
    assign bus.data_out   = data_r;
    assign bus.data_valid = data_valid_r;
    assign bus.busy       = busy_r;
    assign bus.pkt_error  = pkt_error_r;

endmodule

// File: tb/tb_transport_receive.sv
// Self-checking bench for transport_receive: directed scenarios then randomized packet traffic,
// scored against a packet-level reference model.
module tb_transport_receive;

    localparam int PS = 16;
    localparam int NS = (PS - 2) / 2;

`ifdef TRANSPORT_RCV_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    transport_receive_if bus();

    transport_receive #(.PACKET_SIZE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          strobes  = 0;
    logic [7:0]  pkt_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] exp_data = 16'h0000;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Packet-level validity of a completed packet held in pkt_q.
    function automatic bit packet_bad();
        if (pkt_q[0] == 8'h40) begin
            for (int k = 3; k < PS; k++)
                if (pkt_q[k] != 8'h00) return 1'b1;
            return 1'b0;
        end else if (pkt_q[0] == 8'h81) begin
            return pkt_q[PS-1] != 8'hFF;
        end else begin
            return 1'b1;
        end
    endfunction

    // Drive one cycle, then compare every output against the model.
    task automatic step(input bit v, input logic [7:0] b);
        bit         e_dv  = 1'b0;
        logic [1:0] e_cmd = 2'b00;
        bit         e_err = 1'b0;
        int         i     = 0;
        bus.byte_valid = v;
        bus.byte_in    = b;
        @(posedge clk);
        #1;
        if (v) begin
            pkt_q.push_back(b);
            i = pkt_q.size() - 1;
            if (pkt_q[0] == 8'h40 && i == 2) begin
                e_dv = 1'b1; e_cmd = 2'b01; exp_data = {pkt_q[1], pkt_q[2]};
            end else if (pkt_q[0] == 8'h81 && i >= 2 && (i % 2) == 0 && i <= 2 * NS) begin
                e_dv = 1'b1; e_cmd = 2'b10; exp_data = {pkt_q[i-1], pkt_q[i]};
            end
            if (i == PS - 1) begin
                e_err = CHK && packet_bad();
                pkt_q.delete();
            end
        end else begin
            e_err = (pkt_q.size() > 0);
            pkt_q.delete();
        end
        if (bus.data_valid === 1'b1) strobes++;
        check_val("data_valid", 32'(bus.data_valid), 32'(e_dv));
        check_val("cmd_out",    32'(bus.cmd_out),    32'(e_cmd));
        check_val("data_out",   32'(bus.data_out),   32'(exp_data));
        check_val("pkt_error",  32'(bus.pkt_error),  32'(e_err));
        check_val("busy",       32'(bus.busy),       32'(v));
    endtask

    task automatic build_ctrl(input logic [15:0] w, input bit bad);
        tx_q.delete();
        tx_q.push_back(8'h40);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
        for (int k = 3; k < PS; k++) tx_q.push_back(8'h00);
        if (bad) tx_q[$urandom_range(3, PS - 1)] = 8'($urandom_range(1, 255));
    endtask

    task automatic build_audio(input bit seq, input bit bad);
        tx_q.delete();
        tx_q.push_back(8'h81);
        for (int k = 1; k < PS - 1; k++) tx_q.push_back(seq ? 8'(8'hA0 + k) : 8'($urandom));
        tx_q.push_back(bad ? 8'($urandom_range(0, 254)) : 8'hFF);
    endtask

    task automatic build_other(input logic [7:0] hdr);
        tx_q.delete();
        tx_q.push_back(hdr);
        for (int k = 1; k < PS; k++) tx_q.push_back(8'($urandom));
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++) step(1'b1, tx_q[k]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_data_valid"}, 32'(bus.data_valid), 32'd0);
        check_val({tag, "_cmd_out"},    32'(bus.cmd_out),    32'd0);
        check_val({tag, "_data_out"},   32'(bus.data_out),   32'd0);
        check_val({tag, "_busy"},       32'(bus.busy),       32'd0);
        check_val({tag, "_pkt_error"},  32'(bus.pkt_error),  32'd0);
    endtask

    initial begin
        int         kind;
        int         n;
        logic [7:0] hdr;

        reset          = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        #12;
        check_reset_outputs("reset");
        reset = 1'b0;

        // 1: control packet
        strobes = 0;
        build_ctrl(16'h1234, 1'b0);
        send(PS);
        idle(1);
        check_val("t1_strobes", 32'(strobes), 32'd1);

        // 2: audio packet with sequential samples
        strobes = 0;
        build_audio(1'b1, 1'b0);
        send(PS);
        idle(1);
        check_val("t2_strobes", 32'(strobes), 32'd7);

        // 3: two audio packets back to back
        strobes = 0;
        build_audio(1'b1, 1'b0);
        send(PS);
        build_audio(1'b0, 1'b0);
        send(PS);
        idle(1);
        check_val("t3_strobes", 32'(strobes), 32'd14);

        // 4: truncated audio packet after byte 5
        strobes = 0;
        build_audio(1'b1, 1'b0);
        send(6);
        idle(2);
        check_val("t4_strobes", 32'(strobes), 32'd2);

        // 5: unknown header
        strobes = 0;
        build_other(8'h55);
        send(PS);
        idle(1);
        check_val("t5_strobes", 32'(strobes), 32'd0);

        // 6: reset mid audio packet, then a clean control packet
        build_audio(1'b1, 1'b0);
        send(7);
        reset          = 1'b1;
        bus.byte_valid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        pkt_q.delete();
        exp_data = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        strobes = 0;
        build_ctrl(16'hBEEF, 1'b0);
        send(PS);
        idle(1);
        check_val("t6_strobes", 32'(strobes), 32'd1);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: build_ctrl(16'($urandom), ($urandom_range(0, 3) == 0));
                1, 2: build_audio(1'b0, ($urandom_range(0, 3) == 0));
                default: begin
                    hdr = 8'($urandom);
                    if (hdr == 8'h40 || hdr == 8'h81) hdr = 8'h55;
                    build_other(hdr);
                end
            endcase
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, PS - 1)) : PS;
            send(n);
            if (n < PS) idle(1);
            else idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
